// File: rtl/pll_rst_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / downstream reset consumers.
// master: sequencer side; slave: PLL lock source and reset consumers.
interface pll_rst_sequencer_if;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    modport master (
        input  locked,
        output pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
    );

    modport slave (
        output locked,
        input  pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/pll_rst_sequencer.sv
// PLL reset sequencer / lock supervisor on refclk; releases sys_rst after stable lock.
// `PLL_RST_SEQ_RETRY_EN enables the lock timeout, retry counting and FAIL state.
//   state     | meaning
//   RESET_PLL | pll_rst held for PLL_RST_CYCLES
//   WAIT_LOCK | waiting for synchronized lock (optionally with timeout)
//   STABLE    | lock must stay high for STABLE_CYCLES
//   RUN       | sys_rst released, ready high
//   FAIL      | retries exhausted, PLL held in reset until rst
module pll_rst_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_rst_sequencer_if.master  pll
);

    if (SYNC_STAGES < 2)                      begin : g_bad_sync   $error("SYNC_STAGES must be >= 2"); end
    if (PLL_RST_CYCLES < 1)                   begin : g_bad_rst    $error("PLL_RST_CYCLES must be >= 1"); end
    if (STABLE_CYCLES < 1)                    begin : g_bad_stable $error("STABLE_CYCLES must be >= 1"); end
    if (LOCK_TIMEOUT < 1)                     begin : g_bad_to     $error("LOCK_TIMEOUT must be >= 1"); end
    if (MAX_RETRIES < 0 || MAX_RETRIES > 15)  begin : g_bad_retry  $error("MAX_RETRIES must be 0..15"); end

`ifdef PLL_RST_SEQ_RETRY_EN
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
`else
    localparam int CNT_MAX   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_RST_SEQ_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);
`endif

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               cnt_en;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               locked_s;
    logic [7:0]         loss_q, loss_next;
    logic               pll_rst_q, sys_rst_q, ready_q;
`ifdef PLL_RST_SEQ_RETRY_EN
    logic [3:0]         retry_q, retry_next;
    logic               fail_q;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll.locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        loss_next  = loss_q;
        cnt_en     = 1'b0;
`ifdef PLL_RST_SEQ_RETRY_EN
        retry_next = retry_q;
`endif
        case (state)
            RESET_PLL: begin
                cnt_en = 1'b1;
                if (cnt == PLL_RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE;
                end
`ifdef PLL_RST_SEQ_RETRY_EN
                else begin
                    cnt_en = 1'b1;
                    if (cnt == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_next = FAIL;
                        end else begin
                            retry_next = retry_q + 4'd1;
                            state_next = RESET_PLL;
                        end
                    end
                end
`endif
            end
            STABLE: begin
                cnt_en = 1'b1;
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
`ifdef PLL_RST_SEQ_RETRY_EN
                    retry_next = 4'd0;
`endif
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = RESET_PLL;
                    if (loss_q != 8'hFF) loss_next = loss_q + 8'd1;
                end
            end
            FAIL:    state_next = FAIL;
            default: state_next = RESET_PLL;
        endcase

        // Counter restarts on every state entry, including STABLE -> WAIT_LOCK -> STABLE.
        if (state_next != state) begin
            cnt_next = '0;
        end else if (cnt_en) begin
            cnt_next = cnt + CNT_W'(1);
        end else begin
            cnt_next = cnt;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            loss_q    <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PLL_RST_SEQ_RETRY_EN
            retry_q   <= 4'd0;
            fail_q    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            loss_q    <= loss_next;
            pll_rst_q <= (state_next == RESET_PLL) || (state_next == FAIL);
            sys_rst_q <= (state_next != RUN);
            ready_q   <= (state_next == RUN);
`ifdef PLL_RST_SEQ_RETRY_EN
            retry_q   <= retry_next;
            fail_q    <= (state_next == FAIL);
`endif
        end
    end

    assign pll.pll_rst  = pll_rst_q;
    assign pll.sys_rst  = sys_rst_q;
    assign pll.ready    = ready_q;
    assign pll.loss_cnt = loss_q;
`ifdef PLL_RST_SEQ_RETRY_EN
    assign pll.fail      = fail_q;
    assign pll.retry_cnt = retry_q;
`else
    assign pll.fail      = 1'b0;
    assign pll.retry_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Scoreboard bench for pll_rst_sequencer: stimulus queues expected outputs per edge,
// a negedge monitor pops and compares them against the interface.
module tb_pll_rst_sequencer;

    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int LTO  = 20;
    localparam int STB  = 8;
    localparam int MR   = 2;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    pll_rst_sequencer_if ifc();

    pll_rst_sequencer #(
        .SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LTO),
        .STABLE_CYCLES  (STB),
        .MAX_RETRIES    (MR)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .pll    (ifc.master)
    );

    always #10 refclk = ~refclk;

    int unsigned edge_cnt  = 0;
    int unsigned base_edge = 0;
    always @(posedge refclk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int unsigned at;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] pack(bit pr, bit sr, bit rd, bit fl,
                                         logic [3:0] rc, logic [7:0] lc);
        return {pr, sr, rd, fl, rc, lc};
    endfunction

    task automatic expect_at(int unsigned k, logic [15:0] v, string nm);
        sb.push_back('{base_edge + k, v, nm});
    endtask

    // Called at a negedge; returns at the negedge just before edge k of the current run.
    task automatic goto(int unsigned k);
        while (edge_cnt < base_edge + k - 1) @(negedge refclk);
    endtask

    task automatic do_reset(int unsigned cycles);
        @(negedge refclk);
        rst = 1'b1;
        sb.push_back('{edge_cnt + cycles, pack(1, 1, 0, 0, 4'd0, 8'd0), "reset_vals"});
        repeat (cycles) @(negedge refclk);
        rst = 1'b0;
        base_edge = edge_cnt;
    endtask

    always @(negedge refclk) begin
        logic [15:0] obs;
        obs = {ifc.pll_rst, ifc.sys_rst, ifc.ready, ifc.fail, ifc.retry_cnt, ifc.loss_cnt};
        checks++;
        if (ifc.pll_rst === 1'b1 && ifc.sys_rst === 1'b0) begin
            errors++;
            $display("FAIL overlap @edge %0d: pll_rst=1 while sys_rst=0", edge_cnt);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_cnt) begin
                checks++;
                if (obs !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @edge %0d: got {pr,sr,rdy,fail,retry,loss}=%h expected %h",
                             sb[i].name, edge_cnt, obs, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].at < edge_cnt) begin
                errors++;
                $display("FAIL %s: edge %0d never observed", sb[i].name, sb[i].at);
                sb.delete(i);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        ifc.locked = 1'b0;

        // Bring-up, loss of lock and relock
        do_reset(3);
        expect_at(3,  pack(1, 1, 0, 0, 4'd0, 8'd0), "bu_prst_high");
        expect_at(4,  pack(0, 1, 0, 0, 4'd0, 8'd0), "bu_prst_fall");
        expect_at(19, pack(0, 1, 0, 0, 4'd0, 8'd0), "bu_pre_run");
        expect_at(20, pack(0, 0, 1, 0, 4'd0, 8'd0), "bu_run");
        goto(10);
        ifc.locked = 1'b1;
        goto(25);
        ifc.locked = 1'b0;
        expect_at(26, pack(0, 0, 1, 0, 4'd0, 8'd0), "loss_still_run");
        expect_at(27, pack(1, 1, 0, 0, 4'd0, 8'd1), "loss_rereset");
        expect_at(30, pack(1, 1, 0, 0, 4'd0, 8'd1), "loss_prst_held");
        expect_at(31, pack(0, 1, 0, 0, 4'd0, 8'd1), "loss_prst_fall");
        goto(33);
        ifc.locked = 1'b1;
        expect_at(42, pack(0, 1, 0, 0, 4'd0, 8'd1), "relock_pre_run");
        expect_at(43, pack(0, 0, 1, 0, 4'd0, 8'd1), "relock_run");
        goto(46);

        // Lock glitch during STABLE
        ifc.locked = 1'b0;
        do_reset(2);
        expect_at(15, pack(0, 1, 0, 0, 4'd0, 8'd0), "gl_stable");
        expect_at(16, pack(0, 1, 0, 0, 4'd0, 8'd0), "gl_wait");
        expect_at(19, pack(0, 1, 0, 0, 4'd0, 8'd0), "gl_restable");
        expect_at(20, pack(0, 1, 0, 0, 4'd0, 8'd0), "gl_no_early_run");
        expect_at(26, pack(0, 1, 0, 0, 4'd0, 8'd0), "gl_pre_run");
        expect_at(27, pack(0, 0, 1, 0, 4'd0, 8'd0), "gl_run");
        goto(10);
        ifc.locked = 1'b1;
        goto(14);
        ifc.locked = 1'b0;
        goto(17);
        ifc.locked = 1'b1;
        goto(30);

`ifdef PLL_RST_SEQ_RETRY_EN
        // Timeout retries then FAIL
        ifc.locked = 1'b0;
        do_reset(3);
        expect_at(23,  pack(0, 1, 0, 0, 4'd0, 8'd0), "to_wait1");
        expect_at(24,  pack(1, 1, 0, 0, 4'd1, 8'd0), "to_retry1");
        expect_at(27,  pack(1, 1, 0, 0, 4'd1, 8'd0), "to_retry1_end");
        expect_at(28,  pack(0, 1, 0, 0, 4'd1, 8'd0), "to_wait2");
        expect_at(47,  pack(0, 1, 0, 0, 4'd1, 8'd0), "to_wait2_end");
        expect_at(48,  pack(1, 1, 0, 0, 4'd2, 8'd0), "to_retry2");
        expect_at(51,  pack(1, 1, 0, 0, 4'd2, 8'd0), "to_retry2_end");
        expect_at(52,  pack(0, 1, 0, 0, 4'd2, 8'd0), "to_wait3");
        expect_at(71,  pack(0, 1, 0, 0, 4'd2, 8'd0), "to_wait3_end");
        expect_at(72,  pack(1, 1, 0, 1, 4'd2, 8'd0), "to_fail");
        expect_at(172, pack(1, 1, 0, 1, 4'd2, 8'd0), "to_fail_sticky");
        goto(175);
`else
        // No timeout: waits forever, then locks
        ifc.locked = 1'b0;
        do_reset(3);
        expect_at(3,   pack(1, 1, 0, 0, 4'd0, 8'd0), "nt_prst_high");
        expect_at(4,   pack(0, 1, 0, 0, 4'd0, 8'd0), "nt_prst_fall");
        expect_at(24,  pack(0, 1, 0, 0, 4'd0, 8'd0), "nt_no_retry24");
        expect_at(48,  pack(0, 1, 0, 0, 4'd0, 8'd0), "nt_no_retry48");
        expect_at(72,  pack(0, 1, 0, 0, 4'd0, 8'd0), "nt_no_fail72");
        expect_at(500, pack(0, 1, 0, 0, 4'd0, 8'd0), "nt_wait500");
        expect_at(510, pack(0, 1, 0, 0, 4'd0, 8'd0), "nt_pre_run");
        expect_at(511, pack(0, 0, 1, 0, 4'd0, 8'd0), "nt_run");
        goto(501);
        ifc.locked = 1'b1;
        goto(514);
`endif

        // Reset pulse mid-operation after three losses (and one retry when enabled)
        ifc.locked = 1'b0;
        do_reset(3);
        expect_at(15, pack(0, 0, 1, 0, 4'd0, 8'd0), "mid_run1");
        expect_at(18, pack(1, 1, 0, 0, 4'd0, 8'd1), "mid_loss1");
        expect_at(33, pack(0, 0, 1, 0, 4'd0, 8'd1), "mid_run2");
        expect_at(51, pack(0, 0, 1, 0, 4'd0, 8'd2), "mid_run3");
        expect_at(54, pack(1, 1, 0, 0, 4'd0, 8'd3), "mid_loss3");
        expect_at(58, pack(0, 1, 0, 0, 4'd0, 8'd3), "mid_wait");
`ifdef PLL_RST_SEQ_RETRY_EN
        expect_at(78, pack(1, 1, 0, 0, 4'd1, 8'd3), "mid_retry");
        expect_at(84, pack(0, 1, 0, 0, 4'd1, 8'd3), "mid_wait_retry1");
`else
        expect_at(78, pack(0, 1, 0, 0, 4'd0, 8'd3), "mid_no_retry");
        expect_at(84, pack(0, 1, 0, 0, 4'd0, 8'd3), "mid_wait_long");
`endif
        expect_at(85, pack(1, 1, 0, 0, 4'd0, 8'd0), "mid_reset_vals");
        goto(5);
        ifc.locked = 1'b1;
        goto(16);
        ifc.locked = 1'b0;
        goto(23);
        ifc.locked = 1'b1;
        goto(34);
        ifc.locked = 1'b0;
        goto(41);
        ifc.locked = 1'b1;
        goto(52);
        ifc.locked = 1'b0;
        goto(85);
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        base_edge = edge_cnt;
        expect_at(3, pack(1, 1, 0, 0, 4'd0, 8'd0), "mid_restart_prst");
        expect_at(4, pack(0, 1, 0, 0, 4'd0, 8'd0), "mid_restart_fall");
        goto(7);

        repeat (3) @(negedge refclk);
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_rst_sequencer.md
# pll_rst_sequencer

Reset sequencer and lock supervisor on the controlling side of the PLL wrapper. It drives the PLL's `rst` input, watches its asynchronous `locked` output, and releases a synchronous system reset only after lock has been stable for a programmable time. It re-resets the PLL on lock timeout or loss of lock. It runs on the PLL reference clock, so it works while the PLL output is absent.

## Interface
- `SYNC_STAGES`, 2: flop stages of the `locked` synchronizer (≥2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held per reset pulse (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: cycles `locked` must stay high before release (≥1).
- `MAX_RETRIES`, 3: timeout retries before FAIL (0..15).
- `refclk` in 1: 50 MHz reference clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: reset to the PLL, active-high.
- `sys_rst` out 1: synchronous active-high reset for downstream logic.
- `ready` out 1: high in RUN only.
- `fail` out 1: sticky, high in FAIL.
- `retry_cnt` out 4: timeout retries since the last RUN.
- `loss_cnt` out 8: saturating count of lock losses in RUN.

## Operation
- `locked` passes through a `SYNC_STAGES` flop chain to give `locked_s`. The FSM uses only `locked_s`.
- One phase counter is cleared on every state entry.
- **Moore FSM.** Outputs are registered and updated on the same edge as the state.
  - `pll_rst` = 1 in RESET_PLL and FAIL.
  - `sys_rst` = 1 in every state except RUN.
  - `ready` = 1 in RUN.
  - `fail` = 1 in FAIL.
- **RESET_PLL:** when counter = `PLL_RST_CYCLES`-1, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - If `locked_s` is high, go to STABLE.
  - Otherwise, if counter = `LOCK_TIMEOUT`-1:
    - if `retry_cnt` = `MAX_RETRIES`, go to FAIL;
    - else increment `retry_cnt` and go to RESET_PLL.
  - A `locked_s` decision takes priority over timeout on the same cycle.
- **STABLE:**
  - If `locked_s` is low, go to WAIT_LOCK (counter restarts; `retry_cnt` unchanged).
  - Else, if counter = `STABLE_CYCLES`-1, go to RUN and clear `retry_cnt`.
- **RUN:** if `locked_s` is low, increment `loss_cnt` (saturating at 255) and go to RESET_PLL.
- **FAIL:** terminal; only `rst` leaves it.
- **Reset values** while `rst` is high (takes effect at the next edge from any state):
  - state RESET_PLL, counter 0, synchronizer flops 0;
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0.

## Timing
- Edge 1 is the first edge with `rst` low.
  - `pll_rst` is high through edge `PLL_RST_CYCLES`-1 and falls at edge `PLL_RST_CYCLES`.
  - WAIT_LOCK is entered at that same edge.
- `locked` first sampled high at edge k:
  - STABLE entered at edge k+`SYNC_STAGES`;
  - RUN entered (`sys_rst` 0, `ready` 1) at edge k+`SYNC_STAGES`+`STABLE_CYCLES`.
- `locked` sampled low at edge k while in RUN:
  - `sys_rst`=1, `ready`=0, `pll_rst`=1 at edge k+`SYNC_STAGES`;
  - same latency applies to STABLE→WAIT_LOCK.
- WAIT_LOCK entered at edge E with no lock: timeout transition at edge E+`LOCK_TIMEOUT`.
- `sys_rst` never deasserts in the same cycle `pll_rst` is high.
- `sys_rst` asserts together with `pll_rst` on loss of lock.

## Configuration
- Macro `PLL_RST_SEQ_RETRY_EN`.
- **Defined:** WAIT_LOCK timeout, retries, and FAIL behave as above.
- **Undefined:**
  - WAIT_LOCK waits indefinitely for `locked_s`; there is no timeout counter logic.
  - FAIL is unreachable.
  - `fail` and `retry_cnt` are tied to 0.
  - Loss of lock in RUN still re-resets the PLL.

## Test plan
All tests use `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2, macro defined.
- **Bring-up:** `rst` high 3 cycles, `locked` rises before edge 10.
  - `pll_rst` falls at edge 4.
  - `sys_rst` falls and `ready` rises at edge 20.
  - `retry_cnt`=0.
- **STABLE glitch:** `locked` rises at edge 10, low for edges 14–16, high again.
  - Returns to WAIT_LOCK at edge 16; re-enters STABLE at edge 19.
  - RUN at edge 27; `retry_cnt`=0; `pll_rst` never reasserts.
- **Timeout/FAIL:** `locked` held 0.
  - `pll_rst` high at edges 24–27 and 48–51.
  - FAIL at edge 72 with `fail`=1, `pll_rst`=1, `sys_rst`=1, `retry_cnt`=2.
  - Stays in FAIL for 100 further cycles.
- **Loss of lock:** from RUN, `locked` falls before edge k.
  - At edge k+2: `sys_rst`=1, `ready`=0, `pll_rst`=1, `loss_cnt`=1.
  - `pll_rst` falls at edge k+6.
  - Relock restores RUN.
- **Reset mid-operation:** `rst` pulsed for 1 cycle in WAIT_LOCK with `retry_cnt`=1 and `loss_cnt`=3.
  - At the next edge all outputs take reset values and the sequence restarts.
- **Macro undefined:** `locked` held 0 for 500 cycles.
  - `pll_rst` pulses only once; `fail`=0, `retry_cnt`=0, `sys_rst`=1 throughout.
  - `locked` then rising reaches RUN 10 edges later.
